// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//   Round-robin arbiter that hands bytes from two requesters to a single UART
//   byte transmitter. A requester can lock the channel for a burst by
//   presenting last=0 with its byte. A transfer that never sees tx_done aborts
//   after TIMEOUT cycles and sets a sticky error flag.
//
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   req0/1              requester N wants to send; held with data until ackN
//   data0/1             byte from requester N
//   last0/1             1 = final byte of burst, 0 = keep channel locked
//   ack0/1              one-cycle pulse: byte of requester N accepted
//   done0/1             one-cycle pulse: byte of requester N transmitted
//   baud_set_in         desired baud code
//   send_en             one-cycle start pulse to the transmitter
//   data_byte           byte to transmitter, stable from send_en to tx_done
//   baud_set            baud code to transmitter (loads only when idle)
//   tx_done             transmitter completion pulse
//   busy                high whenever not idle
//   owner               current / last granted requester
//   err                 sticky timeout flag, cleared only by reset
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter logic [15:0] TIMEOUT = 16'd60000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    input  logic       last0,
    input  logic       last1,
    output logic       ack0,
    output logic       ack1,
    output logic       done0,
    output logic       done1,
    input  logic [2:0] baud_set_in,
    output logic       send_en,
    output logic [7:0] data_byte,
    output logic [2:0] baud_set,
    input  logic       tx_done,
    output logic       busy,
    output logic       owner,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        NEXT = 2'd2
    } state_t;

    state_t      state;
    logic        ptr;
    logic        lock;
    logic [15:0] cnt;

    logic [1:0]  req_v;
    logic        grant_idx;
    logic [7:0]  grant_data;
    logic        grant_last;
    logic        own_req;
    logic [7:0]  own_data;
    logic        own_last;

    // Requester selection: the pointer holder wins, otherwise the other side.
    always_comb begin
        req_v      = {req1, req0};
        grant_idx  = req_v[ptr] ? ptr : ~ptr;
        grant_data = grant_idx ? data1 : data0;
        grant_last = grant_idx ? last1 : last0;
        own_req    = owner ? req1 : req0;
        own_data   = owner ? data1 : data0;
        own_last   = owner ? last1 : last0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            send_en   <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            data_byte <= '0;
            baud_set  <= '0;
            busy      <= 1'b0;
            owner     <= 1'b0;
            err       <= 1'b0;
            ptr       <= 1'b0;
            lock      <= 1'b0;
            cnt       <= '0;
        end else begin
            send_en <= 1'b0;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            done0   <= 1'b0;
            done1   <= 1'b0;

            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        send_en   <= 1'b1;
                        ack0      <= ~grant_idx;
                        ack1      <= grant_idx;
                        data_byte <= grant_data;
                        owner     <= grant_idx;
                        lock      <= ~grant_last;
                        cnt       <= '0;
                        busy      <= 1'b1;
                        state     <= WAIT;
                    end else begin
                        baud_set <= baud_set_in;
                    end
                end

                WAIT: begin
                    // Completion takes priority over a timeout in the same cycle.
                    if (tx_done) begin
                        done0 <= ~owner;
                        done1 <= owner;
                        state <= NEXT;
                    end else if (cnt >= TIMEOUT - 16'd1) begin
                        err   <= 1'b1;
                        ptr   <= ~owner;
                        lock  <= 1'b0;
                        cnt   <= TIMEOUT;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                NEXT: begin
                    if (lock && own_req) begin
                        send_en   <= 1'b1;
                        ack0      <= ~owner;
                        ack1      <= owner;
                        data_byte <= own_data;
                        lock      <= ~own_last;
                        cnt       <= '0;
                        state     <= WAIT;
                    end else begin
                        ptr   <= ~owner;
                        lock  <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//   Self-checking bench for uart_tx_arbiter. Requesters are modelled as byte
//   queues; the expected grant order comes from the round-robin / burst-lock
//   rules applied to those queues, and expected timing from the transfer
//   handshake rules.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam logic [15:0] TO = 16'd50;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1;
    logic [7:0] data0, data1;
    logic       last0, last1;
    logic       ack0, ack1, done0, done1;
    logic [2:0] baud_set_in;
    logic       send_en;
    logic [7:0] data_byte;
    logic [2:0] baud_set;
    logic       tx_done;
    logic       busy, owner, err;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0       (req0),
        .req1       (req1),
        .data0      (data0),
        .data1      (data1),
        .last0      (last0),
        .last1      (last1),
        .ack0       (ack0),
        .ack1       (ack1),
        .done0      (done0),
        .done1      (done1),
        .baud_set_in(baud_set_in),
        .send_en    (send_en),
        .data_byte  (data_byte),
        .baud_set   (baud_set),
        .tx_done    (tx_done),
        .busy       (busy),
        .owner      (owner),
        .err        (err)
    );

    int checks   = 0;
    int failures = 0;

    // {last, data} per pending byte
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic       m_ptr;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst_n   = 1'b0;
        req0    = 1'b0;
        req1    = 1'b0;
        data0   = '0;
        data1   = '0;
        last0   = 1'b0;
        last1   = 1'b0;
        tx_done = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drive_reqs;
        req0  = (q0.size() != 0);
        data0 = req0 ? q0[0][7:0] : 8'h00;
        last0 = req0 ? q0[0][8] : 1'b0;
        req1  = (q1.size() != 0);
        data1 = req1 ? q1[0][7:0] : 8'h00;
        last1 = req1 ? q1[0][8] : 1'b0;
    endtask

    function automatic int qsize(input logic g);
        return g ? q1.size() : q0.size();
    endfunction

    function automatic logic [8:0] qfront(input logic g);
        return g ? q1[0] : q0[0];
    endfunction

    task automatic qpop(input logic g);
        if (g) void'(q1.pop_front());
        else   void'(q0.pop_front());
    endtask

    task automatic test_reset;
        rst_n       = 1'b1;
        req0        = 1'b0;
        req1        = 1'b0;
        data0       = 8'h00;
        data1       = 8'h00;
        last0       = 1'b0;
        last1       = 1'b0;
        tx_done     = 1'b0;
        baud_set_in = 3'd0;
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (send_en !== 1'b0 || ack0 !== 1'b0 || ack1 !== 1'b0 || done0 !== 1'b0 ||
            done1 !== 1'b0 || data_byte !== 8'h00 || baud_set !== 3'd0 ||
            busy !== 1'b0 || owner !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL reset_values: se=%b ack=%b%b done=%b%b data=%h baud=%0d busy=%b owner=%b err=%b, required all zero",
                     send_en, ack1, ack0, done1, done0, data_byte, baud_set, busy, owner, err);
        end
        apply_reset();
    endtask

    // Single byte with a long transmit time, then the pointer hand-over.
    task automatic test_single;
        logic bad;
        apply_reset();
        req0 = 1'b1; data0 = 8'hA5; last0 = 1'b1;
        tick();
        checks++;
        if (send_en !== 1'b1 || ack0 !== 1'b1 || ack1 !== 1'b0 || data_byte !== 8'hA5 || owner !== 1'b0) begin
            failures++;
            $display("FAIL single_grant: se=%b ack=%b%b data=%h owner=%b, required se=1 ack=01 data=a5 owner=0",
                     send_en, ack1, ack0, data_byte, owner);
        end
        req0 = 1'b0;
        bad = 1'b0;
        for (int unsigned i = 1; i <= 40; i++) begin
            tick();
            if (send_en !== 1'b0 || done0 !== 1'b0 || busy !== 1'b1 || data_byte !== 8'hA5) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL single_wait: activity or data change during transmit, required quiet with data=a5");
        end
        tx_done = 1'b1; tick(); tx_done = 1'b0;
        checks++;
        if (done0 !== 1'b1 || done1 !== 1'b0 || data_byte !== 8'hA5) begin
            failures++;
            $display("FAIL single_done: done=%b%b data=%h, required done=01 data=a5", done1, done0, data_byte);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL single_idle: busy=%b, required 0", busy);
        end
        // Pointer is now 1: requester 1 must win a simultaneous request.
        req0 = 1'b1; data0 = 8'h01; last0 = 1'b1;
        req1 = 1'b1; data1 = 8'h02; last1 = 1'b1;
        tick();
        checks++;
        if (send_en !== 1'b1 || ack0 !== 1'b0 || ack1 !== 1'b1 || data_byte !== 8'h02 || owner !== 1'b1) begin
            failures++;
            $display("FAIL single_pointer: se=%b ack=%b%b data=%h owner=%b, required se=1 ack=10 data=02 owner=1",
                     send_en, ack1, ack0, data_byte, owner);
        end
        req1 = 1'b0;
        tick(); tx_done = 1'b1; tick(); tx_done = 1'b0;
        checks++;
        if (done1 !== 1'b1 || done0 !== 1'b0) begin
            failures++;
            $display("FAIL single_done1: done=%b%b, required 10", done1, done0);
        end
        tick();
        tick();
        checks++;
        if (send_en !== 1'b1 || ack0 !== 1'b1 || data_byte !== 8'h01) begin
            failures++;
            $display("FAIL single_regrant0: se=%b ack0=%b data=%h, required se=1 ack0=1 data=01", send_en, ack0, data_byte);
        end
        req0 = 1'b0;
    endtask

    // Queue-driven traffic: grants, data, burst locking and handshake timing.
    task automatic test_arbitration(input string name, input int unsigned fixed_d);
        logic       g, lk, again;
        logic [8:0] item;
        int unsigned d, guard;
        apply_reset();
        m_ptr = 1'b0;
        drive_reqs();
        guard = 0;
        while ((q0.size() + q1.size()) > 0 && guard < 200) begin
            guard++;
            g = (qsize(m_ptr) > 0) ? m_ptr : ~m_ptr;
            tx_done = ($urandom_range(0, 3) == 0);  // must be ignored while idle
            tick();
            tx_done = 1'b0;
            do begin
                item = qfront(g);
                checks++;
                if (send_en !== 1'b1 || ack0 !== (g == 1'b0) || ack1 !== (g == 1'b1) ||
                    data_byte !== item[7:0] || owner !== g || busy !== 1'b1 || err !== 1'b0 ||
                    done0 !== 1'b0 || done1 !== 1'b0) begin
                    failures++;
                    $display("FAIL %s_grant: se=%b ack=%b%b data=%h owner=%b busy=%b err=%b, required se=1 owner=%b data=%h",
                             name, send_en, ack1, ack0, data_byte, owner, busy, err, g, item[7:0]);
                end
                lk = ~item[8];
                qpop(g);
                drive_reqs();
                d = (fixed_d > 0) ? fixed_d : $urandom_range(1, 12);
                for (int unsigned i = 1; i <= d; i++) begin
                    tick();
                    checks++;
                    if (send_en !== 1'b0 || ack0 !== 1'b0 || ack1 !== 1'b0 || done0 !== 1'b0 ||
                        done1 !== 1'b0 || busy !== 1'b1) begin
                        failures++;
                        $display("FAIL %s_wait: se=%b ack=%b%b done=%b%b busy=%b, required quiet and busy",
                                 name, send_en, ack1, ack0, done1, done0, busy);
                    end
                end
                tx_done = 1'b1; tick(); tx_done = 1'b0;
                checks++;
                if (done0 !== (g == 1'b0) || done1 !== (g == 1'b1) || send_en !== 1'b0 || busy !== 1'b1) begin
                    failures++;
                    $display("FAIL %s_done: done=%b%b se=%b busy=%b, required done for %b only",
                             name, done1, done0, send_en, busy, g);
                end
                tx_done = ($urandom_range(0, 3) == 0);  // sampled in the hand-over cycle, ignored
                again = lk && (qsize(g) > 0);
                tick();
                tx_done = 1'b0;
                if (!again) begin
                    m_ptr = ~g;
                    checks++;
                    if (busy !== 1'b0 || send_en !== 1'b0 || done0 !== 1'b0 || done1 !== 1'b0) begin
                        failures++;
                        $display("FAIL %s_idle: busy=%b se=%b done=%b%b, required idle", name, busy, send_en, done1, done0);
                    end
                end
            end while (again);
        end
        checks++;
        if (guard >= 200) begin
            failures++;
            $display("FAIL %s_bound: transaction budget expired, required queues drained", name);
        end
    endtask

    task automatic test_timeout;
        logic bad;
        apply_reset();
        req0 = 1'b1; data0 = 8'h5E; last0 = 1'b1;
        req1 = 1'b1; data1 = 8'hE5; last1 = 1'b1;
        tick();
        checks++;
        if (send_en !== 1'b1 || ack0 !== 1'b1 || ack1 !== 1'b0) begin
            failures++;
            $display("FAIL timeout_grant: se=%b ack=%b%b, required se=1 ack=01", send_en, ack1, ack0);
        end
        req0 = 1'b0;
        bad = 1'b0;
        for (int unsigned i = 1; i < TO; i++) begin
            tick();
            if (err !== 1'b0 || busy !== 1'b1 || done0 !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL timeout_early: abort before %0d cycles, required busy with err=0", TO);
        end
        tick();
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || done0 !== 1'b0 || done1 !== 1'b0 || send_en !== 1'b0) begin
            failures++;
            $display("FAIL timeout_abort: err=%b busy=%b done=%b%b se=%b, required err=1 busy=0 no done",
                     err, busy, done1, done0, send_en);
        end
        tick();
        checks++;
        if (send_en !== 1'b1 || ack1 !== 1'b1 || ack0 !== 1'b0 || data_byte !== 8'hE5 || owner !== 1'b1) begin
            failures++;
            $display("FAIL timeout_next: se=%b ack=%b%b data=%h owner=%b, required se=1 ack=10 data=e5 owner=1",
                     send_en, ack1, ack0, data_byte, owner);
        end
        req1 = 1'b0;
        tick(); tx_done = 1'b1; tick(); tx_done = 1'b0;
        checks++;
        if (done1 !== 1'b1 || err !== 1'b1) begin
            failures++;
            $display("FAIL timeout_sticky: done1=%b err=%b, required done1=1 err=1", done1, err);
        end
        apply_reset();
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL timeout_clear: err=%b after reset, required 0", err);
        end
    endtask

    // tx_done in the final cycle before the timeout still completes normally.
    task automatic test_boundary;
        apply_reset();
        req0 = 1'b1; data0 = 8'h3C; last0 = 1'b1;
        tick();
        req0 = 1'b0;
        repeat (TO - 1) tick();
        tx_done = 1'b1; tick(); tx_done = 1'b0;
        checks++;
        if (done0 !== 1'b1 || err !== 1'b0) begin
            failures++;
            $display("FAIL boundary_done: done0=%b err=%b, required done0=1 err=0", done0, err);
        end
        tick();
        checks++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL boundary_idle: err=%b busy=%b, required 0 0", err, busy);
        end
    endtask

    task automatic test_baud;
        logic bad;
        apply_reset();
        baud_set_in = 3'd3;
        tick(); tick();
        checks++;
        if (baud_set !== 3'd3) begin
            failures++;
            $display("FAIL baud_load: baud_set=%0d, required 3", baud_set);
        end
        req0 = 1'b1; data0 = 8'h77; last0 = 1'b1;
        tick();
        req0 = 1'b0;
        baud_set_in = 3'd4;
        bad = (baud_set !== 3'd3);
        repeat (3) begin
            tick();
            if (baud_set !== 3'd3) bad = 1'b1;
        end
        tx_done = 1'b1; tick(); tx_done = 1'b0;
        if (baud_set !== 3'd3) bad = 1'b1;
        tick();
        if (baud_set !== 3'd3 || busy !== 1'b0) bad = 1'b1;
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL baud_frozen: baud_set=%0d busy=%b, required 3 until idle", baud_set, busy);
        end
        tick();
        checks++;
        if (baud_set !== 3'd4) begin
            failures++;
            $display("FAIL baud_update: baud_set=%0d, required 4", baud_set);
        end
        baud_set_in = 3'd5;
        req0 = 1'b1;
        tick();
        req0 = 1'b0;
        checks++;
        if (baud_set !== 3'd4 || send_en !== 1'b1) begin
            failures++;
            $display("FAIL baud_grant_cycle: baud_set=%0d se=%b, required 4 and se=1", baud_set, send_en);
        end
    endtask

    task automatic test_reset_mid;
        apply_reset();
        req0 = 1'b1; data0 = 8'h10; last0 = 1'b1;
        tick();
        req0 = 1'b0;
        tick(); tx_done = 1'b1; tick(); tx_done = 1'b0;
        tick();
        req0 = 1'b1; data0 = 8'h21; last0 = 1'b1;
        req1 = 1'b1; data1 = 8'h42; last1 = 1'b1;
        tick();
        checks++;
        if (ack1 !== 1'b1 || ack0 !== 1'b0 || data_byte !== 8'h42) begin
            failures++;
            $display("FAIL midrst_pre: ack=%b%b data=%h, required ack=10 data=42", ack1, ack0, data_byte);
        end
        req1 = 1'b0;
        req0 = 1'b0;
        tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (send_en !== 1'b0 || ack0 !== 1'b0 || ack1 !== 1'b0 || done0 !== 1'b0 ||
            done1 !== 1'b0 || data_byte !== 8'h00 || baud_set !== 3'd0 ||
            busy !== 1'b0 || owner !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL midrst_values: se=%b ack=%b%b done=%b%b data=%h baud=%0d busy=%b owner=%b err=%b, required all zero",
                     send_en, ack1, ack0, done1, done0, data_byte, baud_set, busy, owner, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tx_done = 1'b1; tick(); tx_done = 1'b0;
        tick();
        checks++;
        if (done0 !== 1'b0 || done1 !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midrst_spurious: done=%b%b busy=%b, required no done and idle", done1, done0, busy);
        end
        req0 = 1'b1; req1 = 1'b1;
        tick();
        checks++;
        if (send_en !== 1'b1 || ack0 !== 1'b1 || ack1 !== 1'b0 || data_byte !== 8'h21) begin
            failures++;
            $display("FAIL midrst_first: se=%b ack=%b%b data=%h, required se=1 ack=01 data=21",
                     send_en, ack1, ack0, data_byte);
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic load_random_queues;
        q0 = {};
        q1 = {};
        repeat ($urandom_range(3, 8)) q0.push_back({1'($urandom_range(0, 1)), 8'($urandom)});
        repeat ($urandom_range(3, 8)) q1.push_back({1'($urandom_range(0, 1)), 8'($urandom)});
    endtask

    initial begin
        test_reset();
        test_single();
        q0 = {9'h1_5A, 9'h1_C3};
        q1 = {9'h0_11, 9'h0_22, 9'h1_33};
        test_arbitration("burst", 2);
        for (int unsigned r = 0; r < 4; r++) begin
            load_random_queues();
            test_arbitration("random", 0);
        end
        test_timeout();
        test_boundary();
        test_baud();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
